// File: rtl/jump_pkg.sv
// Shared encodings and fixed-point constants for the jump physics controller.
package jump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        FLY  = 2'd2,
        DONE = 2'd3
    } jump_state_t;

    localparam int unsigned HEIGHT_SHIFT = 5;
    localparam int unsigned DIST_SHIFT   = 7;

    localparam int unsigned ACC_H_W  = 24;
    localparam int unsigned VEL_W    = 13;
    localparam int unsigned ACC_D_W  = 24;
    localparam int unsigned V_W      = 11;
    localparam int unsigned HEIGHT_W = 9;
    localparam int unsigned DIST_W   = 11;

endpackage

// File: rtl/jump_tick.sv
// Physics-step prescaler: one-cycle tick every TICK_DIV enabled cycles, held at zero while cleared.
module jump_tick #(
    parameter int unsigned TICK_DIV = 420000
) (
    input  logic clk_jump,
    input  logic rst_jump,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_jump) begin
        if (rst_jump || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) cnt <= '0;
            else             cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/jump_physics_ctrl.sv
// Jump trajectory FSM: integrates height/distance once per physics step until landing.
// Define JUMP_OUT_SAT_EN to saturate outputs instead of wrapping them.
module jump_physics_ctrl
    import jump_pkg::*;
#(
    parameter int unsigned TICK_DIV = 420000,
    parameter int unsigned GRAV     = 1
) (
    input  logic                clk_jump,
    input  logic                rst_jump,
    input  logic                i_jump_en,
    input  logic [V_W-1:0]      i_jump_v_init,
    output logic                o_jump_done,
    output logic [DIST_W-1:0]   o_jump_dist,
    output logic [HEIGHT_W-1:0] o_jump_height,
    output logic                o_jump_busy
);

    jump_state_t               state;
    logic [V_W-1:0]            v_lat;
    logic signed [VEL_W-1:0]   vel, vel_nxt;
    logic signed [ACC_H_W-1:0] acc_h, acc_h_nxt;
    logic [ACC_D_W-1:0]        acc_d, acc_d_nxt;
    logic                      step_tick;
    logic                      landing;
    logic [HEIGHT_W-1:0]       height_val;
    logic [DIST_W-1:0]         dist_val;

    jump_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_jump (clk_jump),
        .rst_jump (rst_jump),
        .clr      (state != FLY),
        .en       (state == FLY),
        .tick     (step_tick)
    );

    always_comb begin
        acc_h_nxt = acc_h + ACC_H_W'(vel);
        vel_nxt   = vel - VEL_W'(GRAV);
        acc_d_nxt = acc_d + ACC_D_W'(v_lat);
        landing   = acc_h_nxt[ACC_H_W-1] || (acc_h_nxt == '0);
`ifdef JUMP_OUT_SAT_EN
        height_val = (|acc_h_nxt[ACC_H_W-1:HEIGHT_SHIFT+HEIGHT_W]) ? '1
                   : acc_h_nxt[HEIGHT_SHIFT +: HEIGHT_W];
        dist_val   = (|acc_d_nxt[ACC_D_W-1:DIST_SHIFT+DIST_W]) ? '1
                   : acc_d_nxt[DIST_SHIFT +: DIST_W];
`else
        height_val = acc_h_nxt[HEIGHT_SHIFT +: HEIGHT_W];
        dist_val   = acc_d_nxt[DIST_SHIFT +: DIST_W];
`endif
    end

    always_ff @(posedge clk_jump) begin
        if (rst_jump) begin
            state         <= IDLE;
            v_lat         <= '0;
            vel           <= '0;
            acc_h         <= '0;
            acc_d         <= '0;
            o_jump_done   <= 1'b0;
            o_jump_dist   <= '0;
            o_jump_height <= '0;
            o_jump_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_jump_done   <= 1'b0;
                    o_jump_height <= '0;
                    if (i_jump_en) begin
                        state       <= ARM;
                        v_lat       <= i_jump_v_init;
                        vel         <= VEL_W'(i_jump_v_init);
                        acc_h       <= '0;
                        acc_d       <= '0;
                        o_jump_dist <= '0;
                        o_jump_busy <= 1'b1;
                    end
                end
                ARM: begin
                    if (!i_jump_en) begin
                        state       <= IDLE;
                        o_jump_busy <= 1'b0;
                    end else begin
                        state <= FLY;
                    end
                end
                FLY: begin
                    // Landing wins over a simultaneous drop of the request.
                    if (step_tick && landing) begin
                        state         <= DONE;
                        acc_h         <= acc_h_nxt;
                        vel           <= vel_nxt;
                        acc_d         <= acc_d_nxt;
                        o_jump_height <= '0;
                        o_jump_dist   <= dist_val;
                        o_jump_done   <= 1'b1;
                        o_jump_busy   <= 1'b0;
                    end else if (!i_jump_en) begin
                        state         <= IDLE;
                        o_jump_height <= '0;
                        o_jump_busy   <= 1'b0;
                    end else if (step_tick) begin
                        acc_h         <= acc_h_nxt;
                        vel           <= vel_nxt;
                        acc_d         <= acc_d_nxt;
                        o_jump_height <= height_val;
                        o_jump_dist   <= dist_val;
                    end
                end
                DONE: begin
                    if (!i_jump_en) begin
                        state       <= IDLE;
                        o_jump_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jump_physics_ctrl.sv
// Scoreboard bench for jump_physics_ctrl (TICK_DIV = 4, GRAV = 1); expectations from closed-form kinematics.
module tb_jump_physics_ctrl;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned GRAV     = 1;

    logic        clk_jump = 1'b0;
    logic        rst_jump;
    logic        i_jump_en;
    logic [10:0] i_jump_v_init;
    logic        o_jump_done;
    logic [10:0] o_jump_dist;
    logic [8:0]  o_jump_height;
    logic        o_jump_busy;

    jump_physics_ctrl #(.TICK_DIV(TICK_DIV), .GRAV(GRAV)) dut (
        .clk_jump      (clk_jump),
        .rst_jump      (rst_jump),
        .i_jump_en     (i_jump_en),
        .i_jump_v_init (i_jump_v_init),
        .o_jump_done   (o_jump_done),
        .o_jump_dist   (o_jump_dist),
        .o_jump_height (o_jump_height),
        .o_jump_busy   (o_jump_busy)
    );

    always #5 clk_jump = ~clk_jump;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check_val(input string tag, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    endtask

    typedef struct {
        int h;
        int d;
        int done;
        int busy;
    } exp_t;

    exp_t exp_q[$];

    int cyc = 0;
    int start_cyc;
    int done_rise_cyc;
    logic done_prev = 1'b0;

    always @(posedge clk_jump) cyc++;

    always @(negedge clk_jump) begin
        if (o_jump_done && !done_prev) done_rise_cyc = cyc;
        done_prev = o_jump_done;
    end

    function automatic int fold_h(input int sh);
`ifdef JUMP_OUT_SAT_EN
        return (sh > 511) ? 511 : sh;
`else
        return sh & 511;
`endif
    endfunction

    function automatic int fold_d(input int sh);
`ifdef JUMP_OUT_SAT_EN
        return (sh > 2047) ? 2047 : sh;
`else
        return sh & 2047;
`endif
    endfunction

    task automatic push_exp(input int h, input int d, input int done, input int busy);
        exp_t e;
        e.h = h; e.d = d; e.done = done; e.busy = busy;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue"}, exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        check_val({tag, "_height"}, int'(o_jump_height), e.h);
        check_val({tag, "_dist"},   int'(o_jump_dist),   e.d);
        check_val({tag, "_done"},   int'(o_jump_done),   e.done);
        check_val({tag, "_busy"},   int'(o_jump_busy),   e.busy);
    endtask

    // mode 0: land and hold request; 1: abort after stop_step; 2: reset after stop_step;
    // 3: request dropped on the landing edge.
    task automatic run_jump(input int v, input int mode, input int stop_step,
                            output int peak, output int final_dist);
        int n_land, ah, vl, last, sh_h, sh_d, d_hold;
        ah = 0; vl = v; n_land = 0;
        for (int k = 1; k <= 20000; k++) begin
            ah += vl;
            vl -= int'(GRAV);
            if (ah <= 0) begin n_land = k; break; end
        end
        last = (mode == 1 || mode == 2) ? stop_step : n_land;
        peak = 0;
        d_hold = 0;

        i_jump_v_init = 11'(v);
        i_jump_en     = 1'b1;
        start_cyc     = cyc;
        @(negedge clk_jump);
        push_exp(0, 0, 0, 1);
        check_out("start");
        @(negedge clk_jump);
        push_exp(0, 0, 0, 1);
        check_out("arm");

        for (int k = 1; k <= last; k++) begin
            sh_h = (v * k - int'(GRAV) * k * (k - 1) / 2) >> 5;
            sh_d = (v * k) >> 7;
            d_hold = fold_d(sh_d);
            if (k == n_land) push_exp(0, d_hold, 1, 0);
            else             push_exp(fold_h(sh_h), d_hold, 0, 1);
            if (mode == 3 && k == n_land) begin
                repeat (TICK_DIV - 1) @(negedge clk_jump);
                i_jump_en = 1'b0;
                @(negedge clk_jump);
            end else begin
                repeat (TICK_DIV) @(negedge clk_jump);
            end
            check_out("step");
            if (int'(o_jump_height) > peak) peak = int'(o_jump_height);
        end
        final_dist = int'(o_jump_dist);

        case (mode)
            0: begin
                repeat (5) begin
                    @(negedge clk_jump);
                    push_exp(0, d_hold, 1, 0);
                    check_out("done_hold");
                end
                i_jump_en = 1'b0;
                @(negedge clk_jump);
                push_exp(0, d_hold, 0, 0);
                check_out("done_exit");
            end
            1: begin
                i_jump_en = 1'b0;
                @(negedge clk_jump);
                push_exp(0, d_hold, 0, 0);
                check_out("abort");
                repeat (8) begin
                    @(negedge clk_jump);
                    push_exp(0, d_hold, 0, 0);
                    check_out("abort_idle");
                end
            end
            2: begin
                rst_jump  = 1'b1;
                i_jump_en = 1'b0;
                @(negedge clk_jump);
                push_exp(0, 0, 0, 0);
                check_out("reset");
                rst_jump = 1'b0;
                @(negedge clk_jump);
                push_exp(0, 0, 0, 0);
                check_out("reset_idle");
            end
            default: begin
                @(negedge clk_jump);
                push_exp(0, d_hold, 0, 0);
                check_out("prio_exit");
            end
        endcase
        repeat (2) @(negedge clk_jump);
    endtask

    int peak, fdist;

    initial begin
        rst_jump      = 1'b1;
        i_jump_en     = 1'b0;
        i_jump_v_init = '0;
        done_rise_cyc = -1;
        repeat (3) @(negedge clk_jump);
        push_exp(0, 0, 0, 0);
        check_out("por");
        rst_jump = 1'b0;
        @(negedge clk_jump);

        run_jump(127, 0, 0, peak, fdist);
        check_val("v127_peak", peak, 254);
        check_val("v127_dist", fdist, 253);
        check_val("v127_done_lat_ok",
                  int'((done_rise_cyc - start_cyc) >= 1020 && (done_rise_cyc - start_cyc) <= 1024), 1);

        run_jump(1, 0, 0, peak, fdist);
        check_val("v1_peak", peak, 0);
        check_val("v1_dist", fdist, 0);

        run_jump(0, 0, 0, peak, fdist);
        check_val("v0_dist", fdist, 0);

        done_rise_cyc = -1;
        run_jump(127, 1, 50, peak, fdist);
        check_val("abort_dist", int'(o_jump_dist), 49);
        check_val("abort_no_done", done_rise_cyc, -1);

        run_jump(127, 2, 100, peak, fdist);
        run_jump(1, 3, 0, peak, fdist);
        run_jump(2047, 0, 0, peak, fdist);
        run_jump(5, 0, 0, peak, fdist);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/jump_physics_ctrl.md
JUMP_PHYSICS_CTRL -- requirements
Module: jump_physics_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-002 Parameter TICK_DIV, default 420000, is the number of clk_jump cycles per physics step (about 60 Hz at 25.175 MHz). Legal range: 2 or more.
REQ-003 Parameter GRAV, default 1, is the per-step vertical velocity decrement. Legal range: 1..15.
REQ-004 Port clk_jump, input, 1 bit: system clock.
REQ-005 Port rst_jump, input, 1 bit: synchronous active-high reset.
REQ-006 Port i_jump_en, input, 1 bit: jump request level from the game FSM.
REQ-007 Port i_jump_v_init, input, 11 bits: unsigned launch speed, sampled at start.
REQ-008 Port o_jump_done, output, 1 bit: landing indication.
REQ-009 Port o_jump_dist, output, 11 bits: horizontal distance travelled.
REQ-010 Port o_jump_height, output, 9 bits: current height above block.
REQ-011 Port o_jump_busy, output, 1 bit: high in ARM and FLY.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, ARM, FLY, DONE.
REQ-013 IDLE to ARM SHALL occur when i_jump_en = 1.
- In the same edge: latch V = i_jump_v_init, set vel = V, set acc_h = 0, set acc_d = 0.
- Zero the tick prescaler, o_jump_dist and o_jump_height.
REQ-014 ARM SHALL last exactly one cycle, then go to FLY.
REQ-015 In FLY, the prescaler SHALL assert a step every TICK_DIV cycles. The first step comes TICK_DIV cycles after FLY entry.
REQ-016 On each step, using pre-step values:
- acc_h <= acc_h + vel
- vel <= vel - GRAV
- acc_d <= acc_d + V
REQ-017 Widths SHALL be: acc_h signed 24-bit, vel signed 13-bit, acc_d unsigned 24-bit. None of these overflows for any legal input.
REQ-018 Outputs SHALL be registered from the post-step accumulators and valid the cycle after the step:
- o_jump_height = acc_h >> 5
- o_jump_dist = acc_d >> 7
REQ-019 If post-step acc_h <= 0, the FSM SHALL go to DONE. The same edge forces o_jump_height = 0 and keeps o_jump_dist.
- The jump therefore lasts 2V/GRAV + 1 steps (exact for GRAV = 1).
REQ-020 In DONE, o_jump_done SHALL be 1 and outputs SHALL hold. DONE exits to IDLE on the first cycle with i_jump_en = 0.
REQ-021 Abort: if i_jump_en = 0 during ARM or FLY, the FSM SHALL go to IDLE next edge with o_jump_height = 0, o_jump_dist held, and no o_jump_done.
REQ-022 When i_jump_en drops on the same edge as a landing step, landing SHALL take priority: go to DONE, then IDLE on the next cycle.
REQ-023 In IDLE, o_jump_dist SHALL hold its last value, o_jump_height = 0, and o_jump_done = 0.
REQ-024 V = 0 SHALL land on the first step, with height 0 and dist 0.

Reset
REQ-025 When rst_jump = 1 at a clock edge, the block SHALL enter IDLE, regardless of the current state.
REQ-026 Reset SHALL zero all outputs, the accumulators, vel, V and the prescaler.
REQ-027 Reset SHALL override every other event in that cycle.

Configuration
REQ-028 With JUMP_OUT_SAT_EN defined, the outputs SHALL saturate:
- o_jump_height = 511 when acc_h >> 5 exceeds 511.
- o_jump_dist = 2047 when acc_d >> 7 exceeds 2047.
REQ-029 Without JUMP_OUT_SAT_EN, both outputs SHALL be the low 9 and 11 bits of the shifted value (wrap).

Structure
REQ-030 Package jump_pkg SHALL hold:
- the state encoding (IDLE = 0, ARM = 1, FLY = 2, DONE = 3)
- HEIGHT_SHIFT = 5 and DIST_SHIFT = 7
- the accumulator width constants
REQ-031 The prescaler SHALL be sub-module jump_tick, with:
- inputs: clock, reset, clear, enable
- output: one-cycle tick
- parameter: TICK_DIV

Verification (TICK_DIV = 4, GRAV = 1)
REQ-032 V = 127, en held:
- landing after 255 steps
- peak o_jump_height = 254 at steps 127 and 128
- final o_jump_dist = 253
- o_jump_done rises 1022 +/- 2 cycles after en.
REQ-033 V = 1: 3 steps, height stays 0, dist 0, done asserted. V = 0: done after the first step.
REQ-034 V = 127, en dropped after step 50: return to IDLE, height 0, dist = 49, done never asserted.
REQ-035 Done handshake: en held 5 cycles past done → done stays high; en low → IDLE next cycle; en high again → new jump with dist cleared.
REQ-036 rst_jump pulsed at step 100 of a V = 127 jump: next cycle all outputs 0, state IDLE.
REQ-037 V = 2047, with and without JUMP_OUT_SAT_EN: height saturates at 511 (macro) or wraps (no macro). The same check applies to dist.
